// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder with programmable latency
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_error,
    output logic        err_sticky
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        wr_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic        accept;
    logic        commit;
    logic        err;
    logic [AW-1:0] idx;

    // Power-up image of the data array; rst never touches it.
    logic [63:0] mem [DEPTH] = '{
        0: 64'd0,   1: 64'd1,   2: 64'd2,   3: 64'd10,  4: 64'd4,
        5: 64'd5,   6: 64'd6,   7: 64'd7,   8: 64'd8,   9: 64'd9,
        10: 64'd10, 11: 64'd11, 12: 64'd12, 13: 64'd13, 14: 64'd14,
        15: 64'd15, 16: 64'd16, 17: 64'd17, 18: 64'd18, 19: 64'd19,
        20: 64'd20, 128: 64'd4,
        default: 64'd0
    };

    assign accept     = (state == IDLE) && req_valid;
    assign commit     = (state == BUSY) && (cnt == 4'd0);
    assign err        = (addr_q >= 64'(DEPTH));
    assign idx        = addr_q[AW-1:0];
    assign req_ready  = (state == IDLE) && !rst;
    assign resp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = BUSY;
            BUSY:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 4'd0;
            wr_q       <= 1'b0;
            addr_q     <= 64'd0;
            wdata_q    <= 64'd0;
            resp_rdata <= 64'd0;
            resp_error <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt     <= 4'(LATENCY - 1);
            end
            if ((state == BUSY) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                resp_error <= err;
                resp_rdata <= (err || wr_q) ? 64'd0 : mem[idx];
                if (err) begin
                    err_sticky <= 1'b1;
                end
            end
            if ((state == RESP) && resp_ready) begin
                resp_rdata <= 64'd0;
                resp_error <= 1'b0;
            end
        end
    end

    // The write is gated by rst so a commit coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && commit && !err && wr_q) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [63:0] req_addr   [2];
    logic [63:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [63:0] resp_rdata [2];
    logic        resp_error [2];
    logic        err_sticky [2];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [63:0] model [2][1024];
    logic        sticky_m [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH(1024), .LATENCY(2)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]), .err_sticky(err_sticky[0])
    );

    dmem_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]), .err_sticky(err_sticky[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lat(input int u);
        return (u == 0) ? 2 : 1;
    endfunction

    function automatic logic [63:0] init_word(input int i);
        if (i == 3)   return 64'd10;
        if (i <= 20)  return 64'(i);
        if (i == 128) return 64'd4;
        return 64'd0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0;
            resp_ready[u] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("rst_req_ready", 64'(req_ready[u]), 64'd0);
            check("rst_resp_valid", 64'(resp_valid[u]), 64'd0);
            check("rst_resp_rdata", resp_rdata[u], 64'd0);
            check("rst_resp_error", 64'(resp_error[u]), 64'd0);
            check("rst_err_sticky", 64'(err_sticky[u]), 64'd0);
            sticky_m[u] = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("post_rst_req_ready", 64'(req_ready[u]), 64'd1);
            check("post_rst_resp_valid", 64'(resp_valid[u]), 64'd0);
        end
    endtask

    // One full transaction on instance u, stalling the response for 'stall' cycles.
    task automatic txn(input int u, input logic w, input logic [63:0] a,
                       input logic [63:0] d, input int stall);
        logic        e;
        logic [63:0] exp;
        int          k;
        e   = (a >= 64'd1024);
        exp = (e || w) ? 64'd0 : model[u][a[9:0]];
        @(negedge clk);
        check("req_ready_idle", 64'(req_ready[u]), 64'd1);
        req_valid[u]  = 1'b1;
        req_write[u]  = w;
        req_addr[u]   = a;
        req_wdata[u]  = d;
        resp_ready[u] = (stall == 0);
        @(posedge clk);
        #1;
        req_valid[u] = 1'b0;
        req_write[u] = 1'($urandom);
        req_addr[u]  = {$urandom, $urandom};
        req_wdata[u] = {$urandom, $urandom};
        k = 0;
        while (!resp_valid[u] && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("latency", 64'(k), 64'(lat(u)));
        check("resp_rdata", resp_rdata[u], exp);
        check("resp_error", 64'(resp_error[u]), 64'(e));
        if (e) sticky_m[u] = 1'b1;
        else if (w) model[u][a[9:0]] = d;
        for (int s = 0; s < stall; s++) begin
            req_valid[u] = 1'b1;
            @(posedge clk);
            #1;
            check("stall_resp_valid", 64'(resp_valid[u]), 64'd1);
            check("stall_resp_rdata", resp_rdata[u], exp);
            check("stall_resp_error", 64'(resp_error[u]), 64'(e));
            check("stall_req_ready", 64'(req_ready[u]), 64'd0);
        end
        req_valid[u]  = 1'b0;
        resp_ready[u] = 1'b1;
        check("err_sticky", 64'(err_sticky[u]), 64'(sticky_m[u]));
        @(posedge clk);
        #1;
        check("post_hs_resp_valid", 64'(resp_valid[u]), 64'd0);
        check("post_hs_req_ready", 64'(req_ready[u]), 64'd1);
        check("post_hs_rdata", resp_rdata[u], 64'd0);
        check("post_hs_error", 64'(resp_error[u]), 64'd0);
    endtask

    initial begin
        logic [63:0] ra [3];
        logic [63:0] rexp [3];
        int acc [3];
        int j;
        int r;
        int n;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0;
            req_write[u] = 1'b0;
            req_addr[u]  = 64'd0;
            req_wdata[u] = 64'd0;
            resp_ready[u] = 1'b1;
            for (int i = 0; i < 1024; i++) model[u][i] = init_word(i);
        end
        do_reset();

        txn(0, 1'b0, 64'd3, 64'd0, 0);
        txn(0, 1'b1, 64'd500, 64'hDEADBEEF, 0);
        txn(0, 1'b0, 64'd500, 64'd0, 0);
        txn(0, 1'b0, 64'd1024, 64'd0, 0);
        txn(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd55, 0);
        txn(0, 1'b0, 64'd128, 64'd0, 0);
        txn(0, 1'b0, 64'd20, 64'd0, 5);

        // Write aborted by reset in the first BUSY cycle.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 64'd7;
        req_wdata[0] = 64'd77;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_resp_valid", 64'(resp_valid[0]), 64'd0);
        check("abort_err_sticky", 64'(err_sticky[0]), 64'd0);
        do_reset();
        txn(0, 1'b0, 64'd7, 64'd0, 0);

        // Back-to-back reads with req_valid held on the LATENCY=1 instance.
        ra[0] = 64'd1; ra[1] = 64'd2; ra[2] = 64'd3;
        for (int i = 0; i < 3; i++) rexp[i] = model[1][ra[i][9:0]];
        j = 0;
        r = 0;
        n = 0;
        @(negedge clk);
        req_write[1]  = 1'b0;
        req_addr[1]   = ra[0];
        req_valid[1]  = 1'b1;
        resp_ready[1] = 1'b1;
        while (r < 3 && n < 40) begin
            if (j < 3 && req_ready[1]) begin
                acc[j] = cyc + 1;
                if (j > 0) check("b2b_spacing", 64'(acc[j] - acc[j-1]), 64'd3);
                j++;
            end else if (j < 3) begin
                req_addr[1] = ra[j];
            end else begin
                req_valid[1] = 1'b0;
            end
            if (resp_valid[1] && r < j) begin
                check("b2b_rdata", resp_rdata[1], rexp[r]);
                check("b2b_latency", 64'(cyc - acc[r]), 64'd1);
                r++;
            end
            @(negedge clk);
            n++;
        end
        req_valid[1] = 1'b0;
        check("b2b_responses", 64'(r), 64'd3);

        // Random mix on both instances.
        for (int t = 0; t < 150; t++) begin
            int u;
            logic [63:0] a;
            u = int'($urandom_range(1, 0));
            case ($urandom_range(7, 0))
                0:       a = 64'(1024 + $urandom_range(50, 0));
                1:       a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
                2:       a = 64'd1023;
                default: a = 64'($urandom_range(31, 0));
            endcase
            txn(u, 1'($urandom), a, {$urandom, $urandom},
                ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 1)) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
